// File: rtl/lfsr_stream_cipher.sv
// LFSR keystream cipher with valid/ready handshake on both sides.
// Each accepted beat is XORed with DATA_W keystream bits. The LFSR advances
// DATA_W steps in one cycle, and the result is presented one cycle later.
// Encryption and decryption are the same operation when both sides start
// from the same seed.
module lfsr_stream_cipher #(
    parameter int              WIDTH  = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'h002D,
    parameter logic [WIDTH-1:0] SEED  = 16'hACE1,
    parameter int              DATA_W = 8
) (
    input  logic              clock,
    input  logic              n_reset,
    input  logic              seed_load,
    input  logic [WIDTH-1:0]  seed_in,
    output logic              seed_err,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [WIDTH-1:0]  lfsr_state
);

    // Reject illegal configurations while the design is being elaborated.
    generate
        if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
            $error("lfsr_stream_cipher: WIDTH must be within 4..32");
        end
        if (DATA_W < 1 || DATA_W > WIDTH) begin : g_bad_data_w
            $error("lfsr_stream_cipher: DATA_W must be within 1..WIDTH");
        end
        if (SEED == {WIDTH{1'b0}}) begin : g_bad_seed
            $error("lfsr_stream_cipher: SEED must be non-zero");
        end
        if (TAPS == {WIDTH{1'b0}}) begin : g_bad_taps
            $error("lfsr_stream_cipher: TAPS must be non-zero");
        end
    endgenerate

    // XOR-reduce a vector. The feedback bit is the parity of the tapped bits.
    function automatic logic parity_f(input logic [WIDTH-1:0] v);
        parity_f = ^v;
    endfunction

    // Advance the LFSR one step. Feedback enters at the MSB and the state shifts right.
    function automatic logic [WIDTH-1:0] lfsr_step_f(input logic [WIDTH-1:0] s);
        lfsr_step_f = {parity_f(s & TAPS), s[WIDTH-1:1]};
    endfunction

    logic [WIDTH-1:0]  lfsr_q;
    logic [WIDTH-1:0]  lfsr_d;
    logic              out_valid_q;
    logic              out_valid_d;
    logic [DATA_W-1:0] out_data_q;
    logic [DATA_W-1:0] out_data_d;
    logic              seed_err_q;
    logic              seed_err_d;

    logic [WIDTH-1:0]  adv_s;
    logic [DATA_W-1:0] ks_s;
    logic              lockup_s;
    logic              seed_zero_s;
    logic              in_ready_s;
    logic              accept_s;

    // Unroll DATA_W LFSR steps. Keystream bit j is s[0] after j steps.
    always_comb begin
        ks_s  = {DATA_W{1'b0}};
        adv_s = lfsr_q;
        for (int j = 0; j < DATA_W; j++) begin
            ks_s[j] = adv_s[0];
            adv_s   = lfsr_step_f(adv_s);
        end
    end

    // Handshake qualifiers. An all-zero state also blocks intake until it is recovered.
    assign lockup_s    = (lfsr_q == {WIDTH{1'b0}});
    assign seed_zero_s = (seed_in == {WIDTH{1'b0}});
    assign in_ready_s  = !seed_load && !lockup_s && (!out_valid_q || out_ready);
    assign accept_s    = in_valid && in_ready_s;

    // Next state: lock-up recovery, then seed load, then beat advance.
    always_comb begin
        lfsr_d      = lfsr_q;
        seed_err_d  = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (lockup_s) begin
            lfsr_d     = SEED;
            seed_err_d = 1'b1;
        end else if (seed_load) begin
            if (seed_zero_s) begin
                lfsr_d     = lfsr_q;
                seed_err_d = 1'b1;
            end else begin
                lfsr_d     = seed_in;
                seed_err_d = 1'b0;
            end
        end else if (accept_s) begin
            lfsr_d = adv_s;
        end else begin
            lfsr_d = lfsr_q;
        end

        if (accept_s) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data ^ ks_s;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_data_d  = out_data_q;
        end else begin
            out_valid_d = out_valid_q;
            out_data_d  = out_data_q;
        end
    end

    // State and output registers. Reset discards any in-flight beat.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            lfsr_q      <= SEED;
            out_valid_q <= 1'b0;
            out_data_q  <= {DATA_W{1'b0}};
            seed_err_q  <= 1'b0;
        end else begin
            lfsr_q      <= lfsr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            seed_err_q  <= seed_err_d;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign seed_err   = seed_err_q;
    assign lfsr_state = lfsr_q;

endmodule
